// File: rtl/sr_bank_pkg.sv
// ---------------------------------------------------------------------------
// sr_bank_pkg
//   Shared definitions for the clocked SR flip-flop bank.
//   - SR_* constants select how a channel resolves a simultaneous set and
//     reset request (the MODE parameter of sr_ff_cell / sr_ff_bank).
//   - sr_next() is the single-channel next-state function used by every cell.
// ---------------------------------------------------------------------------
package sr_bank_pkg;

    localparam int unsigned SR_HOLD    = 32'd0;  // s=r=1 keeps q
    localparam int unsigned SR_SET_DOM = 32'd1;  // s=r=1 sets q
    localparam int unsigned SR_RST_DOM = 32'd2;  // s=r=1 clears q
    localparam int unsigned SR_TOGGLE  = 32'd3;  // s=r=1 inverts q (JK behaviour)

    // Next state of one channel for an enabled cycle. Every path assigns a
    // known value, so a known q can never turn into X.
    function automatic logic sr_next(
        input logic        q,
        input logic        s,
        input logic        r,
        input int unsigned mode
    );
        logic nxt;
        case ({s, r})
            2'b00: nxt = q;
            2'b01: nxt = 1'b0;
            2'b10: nxt = 1'b1;
            2'b11: begin
                case (mode)
                    SR_HOLD:    nxt = q;
                    SR_SET_DOM: nxt = 1'b1;
                    SR_RST_DOM: nxt = 1'b0;
                    SR_TOGGLE:  nxt = ~q;
                    default:    nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// ---------------------------------------------------------------------------
// sr_ff_cell
//   One clocked SR channel: q, its registered complement and a one-cycle
//   conflict pulse (s=r=1 while enabled).
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous reset, active-low
//   en        in   update enable; 0 holds q and suppresses conflict
//   s, r      in   set / reset request
//   rst_val   in   value loaded into q on reset
//   q         out  registered state
//   qbar      out  registered complement of q
//   conflict  out  registered conflict pulse
//   q_next    out  combinational next state (feeds the bank-level any_q)
// ---------------------------------------------------------------------------
module sr_ff_cell
    import sr_bank_pkg::*;
#(
    parameter int unsigned MODE = SR_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic rst_val,
    output logic q,
    output logic qbar,
    output logic conflict,
    output logic q_next
);

    logic q_r;
    logic qbar_r;
    logic conflict_r;
    logic q_next_s;
    logic conflict_next_s;

    // Next-state and conflict decode for this channel.
    always_comb begin
        q_next_s        = q_r;
        conflict_next_s = 1'b0;
        if (en) begin
            q_next_s        = sr_next(q_r, s, r, MODE);
            conflict_next_s = s & r;
        end else begin
            q_next_s        = q_r;
            conflict_next_s = 1'b0;
        end
    end

    // State, complement and conflict flops; qbar is its own flop so it is
    // always the exact complement without a combinational inverter on the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r        <= rst_val;
            qbar_r     <= ~rst_val;
            conflict_r <= 1'b0;
        end else begin
            q_r        <= q_next_s;
            qbar_r     <= ~q_next_s;
            conflict_r <= conflict_next_s;
        end
    end

    assign q        = q_r;
    assign qbar     = qbar_r;
    assign conflict = conflict_r;
    assign q_next   = q_next_s;

endmodule

// File: rtl/sr_ff_bank.sv
// ---------------------------------------------------------------------------
// sr_ff_bank
//   Bank of N clocked SR flip-flops for status / sticky-flag registers.
//   Optional feature macro: SR_CONFLICT_CNT_EN adds a saturating counter of
//   cycles in which at least one channel reported a conflict.
// Parameters
//   N (1..32), MODE (0..3, see sr_bank_pkg), RST_VAL (N bits), CNT_W (2..16)
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   synchronous reset, active-low
//   en            in   common update enable
//   s, r          in   per-channel set / reset requests
//   q, qbar       out  registered state and complement
//   conflict      out  per-channel one-cycle s=r=1 pulse
//   any_q         out  registered OR of the new q vector
//   cnt_clr       in   clear conflict counter      (SR_CONFLICT_CNT_EN only)
//   conflict_cnt  out  saturating conflict count   (SR_CONFLICT_CNT_EN only)
// ---------------------------------------------------------------------------
module sr_ff_bank
    import sr_bank_pkg::*;
#(
    parameter int unsigned     N       = 8,
    parameter int unsigned     MODE    = SR_HOLD,
    parameter logic [N-1:0]    RST_VAL = {N{1'b0}},
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qbar,
    output logic [N-1:0]     conflict,
    output logic             any_q
`ifdef SR_CONFLICT_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    // Reject unsupported configurations at elaboration time.
    generate
        if (MODE > 32'd3) begin : g_bad_mode
            $error("sr_ff_bank: MODE must be in 0..3");
        end
        if ((N < 32'd1) || (N > 32'd32)) begin : g_bad_n
            $error("sr_ff_bank: N must be in 1..32");
        end
        if ((CNT_W < 32'd2) || (CNT_W > 32'd16)) begin : g_bad_cnt_w
            $error("sr_ff_bank: CNT_W must be in 2..16");
        end
    endgenerate

    logic [N-1:0] q_next_s;
    logic         any_q_r;

    for (genvar i = 0; i < N; i++) begin : g_cell
        sr_ff_cell #(
            .MODE (MODE)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .s        (s[i]),
            .r        (r[i]),
            .rst_val  (RST_VAL[i]),
            .q        (q[i]),
            .qbar     (qbar[i]),
            .conflict (conflict[i]),
            .q_next   (q_next_s[i])
        );
    end

    // any_q is taken from the next-state vector so it lines up with q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_q_r <= |RST_VAL;
        end else begin
            any_q_r <= |q_next_s;
        end
    end

    assign any_q = any_q_r;

`ifdef SR_CONFLICT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             conflict_any_s;
    logic [CNT_W-1:0] cnt_r;

    // One increment per conflicting cycle, however many channels collided.
    assign conflict_any_s = en & (|(s & r));

    // Counter priority: reset, then clear (which swallows a same-cycle
    // conflict), then saturating increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (conflict_any_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign conflict_cnt = cnt_r;
`endif

endmodule
